// File: rtl/tpu_pkg.sv
// Shared definitions for the systolic tile.
// State encodings and accumulator width helper.
package tpu_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;

    localparam int DEF_D_W = 8;

    function automatic int acc_width(input int d_w);
        return 2 * d_w;
    endfunction

endpackage

// File: rtl/output_control_buffer.sv
// Result snapshot register file.
// Parallel load of N*N words, single-bit random read.
module result_buffer #(
    parameter int N     = 2,
    parameter int ACC_W = 16,
    parameter int WI_W  = $clog2(N * N),
    parameter int BI_W  = $clog2(ACC_W)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [N*N*ACC_W-1:0]   data_flat,
    input  logic [WI_W-1:0]        word_idx,
    input  logic [BI_W-1:0]        bit_idx,
    output logic                   sel_bit
);

    logic [ACC_W-1:0] mem [N*N];

    // Capture every word at once on load; clear on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N * N; k++) begin
                mem[k] <= '0;
            end
        end else if (load) begin
            for (int k = 0; k < N * N; k++) begin
                mem[k] <= data_flat[(k+1)*ACC_W-1 -: ACC_W];
            end
        end
    end

    assign sel_bit = mem[word_idx][bit_idx];

endmodule

// File: rtl/output_control.sv
// Serial unloader for the systolic array results.
// Snapshots all accumulators, then shifts them out LSB-first.
module output_control
    import tpu_pkg::*;
#(
    parameter int D_W   = DEF_D_W,
    parameter int N     = 2,
    parameter int ACC_W = acc_width(D_W)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N*N*ACC_W-1:0]   res_flat,
    input  logic                   res_valid,
    input  logic                   read_en,
    output logic                   data_out,
    output logic                   out_valid,
    output logic                   busy,
    output logic                   done,
    output logic                   overrun
);

    localparam int WI_W = $clog2(N * N);
    localparam int BI_W = $clog2(ACC_W);

    localparam logic [BI_W-1:0] BIT_LAST  = BI_W'(ACC_W - 1);
    localparam logic [WI_W-1:0] WORD_LAST = WI_W'(N * N - 1);

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [BI_W-1:0] bit_cnt;
    logic [WI_W-1:0] word_cnt;
    logic            sel_bit;
    logic            load;
    logic            last_bit;

    assign load     = (state == IDLE) && res_valid;
    assign last_bit = (word_cnt == WORD_LAST) && (bit_cnt == BIT_LAST);

    result_buffer #(
        .N     (N),
        .ACC_W (ACC_W),
        .WI_W  (WI_W),
        .BI_W  (BI_W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .data_flat (res_flat),
        .word_idx  (word_cnt),
        .bit_idx   (bit_cnt),
        .sel_bit   (sel_bit)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: leave IDLE on a snapshot, return after the last bit.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (res_valid) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (read_en && last_bit) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Busy covers the shift phase and the cycle carrying the last bit.
    always_comb begin
        busy = (state == SHIFT) || done;
    end

    // Shift datapath, counters and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out  <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
            bit_cnt   <= '0;
            word_cnt  <= '0;
        end else begin
            out_valid <= 1'b0;
            done      <= 1'b0;
            if (state == IDLE) begin
                if (res_valid) begin
                    bit_cnt  <= '0;
                    word_cnt <= '0;
                end
            end else if (state == SHIFT) begin
                if (res_valid) begin
                    overrun <= 1'b1;
                end
                if (read_en) begin
                    data_out  <= sel_bit;
                    out_valid <= 1'b1;
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        if (word_cnt == WORD_LAST) begin
                            word_cnt <= '0;
                            done     <= 1'b1;
                        end else begin
                            word_cnt <= word_cnt + WI_W'(1);
                        end
                    end else begin
                        bit_cnt <= bit_cnt + BI_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_output_control.sv
// Directed bench for the serial result unloader.
// N=2, ACC_W=16; expected bits come from a local word table.
module tb_output_control;

    localparam int N     = 2;
    localparam int ACC_W = 16;
    localparam int NB    = N * N * ACC_W;

    logic                 clk;
    logic                 rst;
    logic [N*N*ACC_W-1:0] res_flat;
    logic                 res_valid;
    logic                 read_en;
    logic                 data_out;
    logic                 out_valid;
    logic                 busy;
    logic                 done;
    logic                 overrun;

    int vecs;
    int errs;

    logic [15:0] w [4];

    output_control #(
        .D_W   (8),
        .N     (N),
        .ACC_W (ACC_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .res_flat  (res_flat),
        .res_valid (res_valid),
        .read_en   (read_en),
        .data_out  (data_out),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic exp_bit(input int i);
        logic [15:0] t;
        t = w[i / 16];
        return t[i % 16];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(
        input logic [15:0] a,
        input logic [15:0] b,
        input logic [15:0] c,
        input logic [15:0] d
    );
        w[0] = a;
        w[1] = b;
        w[2] = c;
        w[3] = d;
        res_flat  = {d, c, b, a};
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vecs++;
        if ({data_out, out_valid, busy, done, overrun} !== 5'b0) begin
            errs++;
            $display("FAIL reset_outs got %b want 00000",
                     {data_out, out_valid, busy, done, overrun});
        end
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            read_en = c[0];
            tick();
            vecs++;
            if ({data_out, out_valid, busy, done, overrun} !== 5'b0) begin
                errs++;
                $display("FAIL idle_outs c=%0d got %b want 00000", c,
                         {data_out, out_valid, busy, done, overrun});
            end
        end
        read_en = 1'b0;
    endtask

    task automatic test_stream();
        load(16'h0001, 16'h8000, 16'hA5A5, 16'hFFFF);
        vecs++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            errs++;
            $display("FAIL load_busy got busy=%b ov=%b want 1 0",
                     busy, out_valid);
        end
        read_en = 1'b1;
        for (int i = 0; i < NB; i++) begin
            tick();
            vecs++;
            if (out_valid !== 1'b1 || data_out !== exp_bit(i) ||
                done !== (i == NB - 1) || busy !== 1'b1) begin
                errs++;
                $display("FAIL stream bit=%0d got ov=%b d=%b dn=%b bz=%b want 1 %b %b 1",
                         i, out_valid, data_out, done, busy,
                         exp_bit(i), (i == NB - 1));
            end
        end
        read_en = 1'b0;
        tick();
        vecs++;
        if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin
            errs++;
            $display("FAIL stream_end got bz=%b dn=%b ov=%b want 0 0 0",
                     busy, done, out_valid);
        end
    endtask

    task automatic test_toggle();
        int n;
        logic prev;
        n = 0;
        prev = data_out;
        load(16'h0001, 16'h8000, 16'hA5A5, 16'hFFFF);
        for (int c = 0; c < 2 * NB; c++) begin
            read_en = (c % 2 == 0);
            tick();
            vecs++;
            if (read_en) begin
                if (out_valid !== 1'b1 || data_out !== exp_bit(n) ||
                    done !== (n == NB - 1)) begin
                    errs++;
                    $display("FAIL toggle_bit c=%0d n=%0d got ov=%b d=%b dn=%b want 1 %b %b",
                             c, n, out_valid, data_out, done,
                             exp_bit(n), (n == NB - 1));
                end
                n++;
            end else begin
                if (out_valid !== 1'b0 || data_out !== prev ||
                    done !== 1'b0) begin
                    errs++;
                    $display("FAIL toggle_hold c=%0d got ov=%b d=%b dn=%b want 0 %b 0",
                             c, out_valid, data_out, done, prev);
                end
            end
            prev = data_out;
        end
        read_en = 1'b0;
        vecs++;
        if (n != NB || busy !== 1'b0) begin
            errs++;
            $display("FAIL toggle_count got n=%0d bz=%b want %0d 0",
                     n, busy, NB);
        end
    endtask

    task automatic test_overrun();
        load(16'h0001, 16'h8000, 16'hA5A5, 16'hFFFF);
        vecs++;
        if (overrun !== 1'b0) begin
            errs++;
            $display("FAIL ovr_pre got %b want 0", overrun);
        end
        read_en = 1'b1;
        for (int i = 0; i < NB; i++) begin
            if (i == 10) begin
                res_flat  = {4{16'h1234}};
                res_valid = 1'b1;
            end
            tick();
            res_valid = 1'b0;
            vecs++;
            if (data_out !== exp_bit(i) || out_valid !== 1'b1 ||
                overrun !== (i >= 10)) begin
                errs++;
                $display("FAIL ovr_stream bit=%0d got d=%b ov=%b or=%b want %b 1 %b",
                         i, data_out, out_valid, overrun,
                         exp_bit(i), (i >= 10));
            end
        end
        read_en = 1'b0;
        tick();
        vecs++;
        if (overrun !== 1'b1 || busy !== 1'b0) begin
            errs++;
            $display("FAIL ovr_sticky got or=%b bz=%b want 1 0",
                     overrun, busy);
        end
    endtask

    task automatic test_mid_reset();
        load(16'h0001, 16'h8000, 16'hA5A5, 16'hFFFF);
        read_en = 1'b1;
        for (int i = 0; i <= 20; i++) begin
            tick();
            vecs++;
            if (data_out !== exp_bit(i)) begin
                errs++;
                $display("FAIL mid_pre bit=%0d got %b want %b",
                         i, data_out, exp_bit(i));
            end
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        read_en = 1'b0;
        vecs++;
        if ({data_out, out_valid, busy, done, overrun} !== 5'b0) begin
            errs++;
            $display("FAIL mid_rst got %b want 00000",
                     {data_out, out_valid, busy, done, overrun});
        end
        load(16'h00FF, 16'h0000, 16'h0000, 16'h0000);
        read_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            vecs++;
            if (out_valid !== 1'b1 || data_out !== (i < 8)) begin
                errs++;
                $display("FAIL mid_new bit=%0d got ov=%b d=%b want 1 %b",
                         i, out_valid, data_out, (i < 8));
            end
        end
        read_en = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_done_collision();
        load(16'h0001, 16'h8000, 16'hA5A5, 16'hFFFF);
        read_en = 1'b1;
        for (int i = 0; i < NB; i++) begin
            if (i == NB - 1) begin
                res_flat  = '0;
                res_valid = 1'b1;
            end
            tick();
            res_valid = 1'b0;
            vecs++;
            if (data_out !== exp_bit(i) || done !== (i == NB - 1) ||
                overrun !== (i == NB - 1)) begin
                errs++;
                $display("FAIL coll_stream bit=%0d got d=%b dn=%b or=%b want %b %b %b",
                         i, data_out, done, overrun, exp_bit(i),
                         (i == NB - 1), (i == NB - 1));
            end
        end
        read_en = 1'b0;
        load(16'h00FF, 16'h0F0F, 16'h0000, 16'h0000);
        vecs++;
        if (busy !== 1'b1 || done !== 1'b0 || overrun !== 1'b1) begin
            errs++;
            $display("FAIL coll_accept got bz=%b dn=%b or=%b want 1 0 1",
                     busy, done, overrun);
        end
        read_en = 1'b1;
        for (int i = 0; i < 32; i++) begin
            tick();
            vecs++;
            if (out_valid !== 1'b1 || data_out !== exp_bit(i)) begin
                errs++;
                $display("FAIL coll_new bit=%0d got ov=%b d=%b want 1 %b",
                         i, out_valid, data_out, exp_bit(i));
            end
        end
        read_en = 1'b0;
    endtask

    initial begin
        vecs      = 0;
        errs      = 0;
        rst       = 1'b1;
        res_flat  = '0;
        res_valid = 1'b0;
        read_en   = 1'b0;
        test_reset();
        test_stream();
        test_toggle();
        test_overrun();
        test_mid_reset();
        test_done_collision();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
